// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32I control FSM (Moore style). Sequences a shared datapath
// with one ALU, one unified memory port and one register file. It covers
// LW, SW, R-type ALU, I-type ALU, BEQ and JAL.
// Optional feature macro: RISCV_MC_ILLEGAL_TRAP_EN
//   When it is defined, an unsupported opcode traps into a terminal ILLEGAL
//   state and raises o_illegal until reset.
//   When it is undefined, an unsupported opcode retires as a 2-cycle NOP.
module riscv_multicycle_controller (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pcWrite,
  output logic       o_adrSrc,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [3:0] o_aluControl,
  output logic [1:0] o_immSrc,
  output logic       o_regWrite,
  output logic       o_retire,
  output logic       o_illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
`else
    S_JAL      = 4'd10
`endif
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic       pc_write_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       retire_s;
  logic       illegal_s;

  // Only the five defined ALU codes pass through. Any other code becomes ADD.
  function automatic logic [3:0] alu_decode(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      4'b0000: res = 4'b0000;
      4'b1000: res = 4'b1000;
      4'b0111: res = 4'b0111;
      4'b0110: res = 4'b0110;
      4'b0100: res = 4'b0100;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Maps the opcode to its immediate format. Opcodes without an immediate give I (00).
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    logic [1:0] res;
    case (op)
      OP_SW:   res = 2'b01;
      OP_B:    res = 2'b10;
      OP_JAL:  res = 2'b11;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // State register: reset parks the FSM in FETCH.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state output decode. Defaults are the idle/ADD values.
  always_comb begin
    next_state_s = S_FETCH;
    pc_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;
    o_adrSrc     = 1'b0;
    o_resultSrc  = 2'b00;
    o_aluSrcA    = 2'b00;
    o_aluSrcB    = 2'b00;
    o_aluControl = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        o_aluSrcB    = 2'b10;
        o_resultSrc  = 2'b10;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
        case (i_op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECUTER;
          OP_I:         next_state_s = S_EXECUTEI;
          OP_B:         next_state_s = S_BEQ;
          OP_JAL:       next_state_s = S_JAL;
          default: begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
            next_state_s = S_ILLEGAL;
`else
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
        if (i_op == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        o_adrSrc     = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultSrc  = 2'b01;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSrc     = 1'b1;
        mem_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_EXECUTER: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = alu_decode({i_funct7b5, i_funct3});
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_aluSrcA    = 2'b10;
        o_aluSrcB    = 2'b01;
        o_aluControl = alu_decode({1'b0, i_funct3});
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = ALU_SUB;
        pc_write_s   = i_zero;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        o_aluSrcA    = 2'b01;
        o_aluSrcB    = 2'b10;
        pc_write_s   = 1'b1;
        next_state_s = S_ALUWB;
      end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      S_ILLEGAL: begin
        illegal_s    = 1'b1;
        next_state_s = S_ILLEGAL;
      end
`endif
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Enables are forced low while reset is held so nothing writes during reset.
  always_comb begin
    o_pcWrite  = pc_write_s  & ~i_arst;
    o_memWrite = mem_write_s & ~i_arst;
    o_irWrite  = ir_write_s  & ~i_arst;
    o_regWrite = reg_write_s & ~i_arst;
    o_retire   = retire_s    & ~i_arst;
    o_illegal  = illegal_s   & ~i_arst;
    o_immSrc   = imm_decode(i_op);
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for riscv_multicycle_controller. The stimulus pushes the
// hand-computed per-cycle output vector for each cycle it drives. A monitor
// pops one vector per cycle on the falling edge and compares it.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       arst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control;

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  riscv_multicycle_controller dut (
    .i_clk(clk), .i_arst(arst), .i_op(op), .i_funct3(funct3),
    .i_funct7b5(funct7b5), .i_zero(zero),
    .o_pcWrite(pc_write), .o_adrSrc(adr_src), .o_memWrite(mem_write),
    .o_irWrite(ir_write), .o_resultSrc(result_src), .o_aluSrcA(alu_src_a),
    .o_aluSrcB(alu_src_b), .o_aluControl(alu_control), .o_immSrc(imm_src),
    .o_regWrite(reg_write), .o_retire(retire), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  // Vector layout: pcw adr mw irw rs[2] sa[2] sb[2] alu[4] imm[2] rw ret ill
  function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [3:0] alu, input logic [1:0] imm,
                                     input logic rw, input logic ret, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret, ill};
  endfunction

  function automatic logic [18:0] v_fetch(input logic [1:0] imm);
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 4'b0000, imm, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] v_decode(input logic [1:0] imm, input logic ret);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'b0000, imm, 1'b0, ret, 1'b0);
  endfunction

  function automatic logic [18:0] v_reset(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0000, imm, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] v_aluwb(input logic [1:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, imm, 1'b1, 1'b1, 1'b0);
  endfunction

  task automatic expect_cycle(input string name, input logic [18:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [18:0] act;
    logic [18:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
             alu_control, imm_src, reg_write, retire, illegal};
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got %b required %b (pcw adr mw irw rs sa sb alu imm rw ret ill)",
                 nm, act, e);
      end
    end
  end

  initial begin
    arst = 1'b1;
    set_in(7'b0000011, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_cycle("reset_hold", v_reset(2'b00));
    step(1);
    arst = 1'b0;

    // LW: 5 cycles
    expect_cycle("lw_fetch", v_fetch(2'b00));
    expect_cycle("lw_decode", v_decode(2'b00, 1'b0));
    expect_cycle("lw_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("lw_memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("lw_memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0));
    step(5);

    // SW: 4 cycles, immSrc S
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    expect_cycle("sw_fetch", v_fetch(2'b01));
    expect_cycle("sw_decode", v_decode(2'b01, 1'b0));
    expect_cycle("sw_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0));
    expect_cycle("sw_memwrite", mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0));
    step(4);

    // R-type SUB (funct7b5=1, funct3=000)
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
    expect_cycle("r_sub_fetch", v_fetch(2'b00));
    expect_cycle("r_sub_decode", v_decode(2'b00, 1'b0));
    expect_cycle("r_sub_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("r_sub_aluwb", v_aluwb(2'b00));
    step(4);

    // I-type with the same fields: funct7b5 ignored -> ADD
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    expect_cycle("i_add_fetch", v_fetch(2'b00));
    expect_cycle("i_add_decode", v_decode(2'b00, 1'b0));
    expect_cycle("i_add_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("i_add_aluwb", v_aluwb(2'b00));
    step(4);

    // I-type ORI (funct3=110) -> OR
    set_in(7'b0010011, 3'b110, 1'b0, 1'b0);
    expect_cycle("i_or_fetch", v_fetch(2'b00));
    expect_cycle("i_or_decode", v_decode(2'b00, 1'b0));
    expect_cycle("i_or_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0110, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("i_or_aluwb", v_aluwb(2'b00));
    step(4);

    // R-type AND, XOR, and an undefined code (1111) that falls back to ADD
    set_in(7'b0110011, 3'b111, 1'b0, 1'b0);
    expect_cycle("r_and_fetch", v_fetch(2'b00));
    expect_cycle("r_and_decode", v_decode(2'b00, 1'b0));
    expect_cycle("r_and_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0111, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("r_and_aluwb", v_aluwb(2'b00));
    step(4);
    set_in(7'b0110011, 3'b100, 1'b0, 1'b0);
    expect_cycle("r_xor_fetch", v_fetch(2'b00));
    expect_cycle("r_xor_decode", v_decode(2'b00, 1'b0));
    expect_cycle("r_xor_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("r_xor_aluwb", v_aluwb(2'b00));
    step(4);
    set_in(7'b0110011, 3'b111, 1'b1, 1'b0);
    expect_cycle("r_undef_fetch", v_fetch(2'b00));
    expect_cycle("r_undef_decode", v_decode(2'b00, 1'b0));
    expect_cycle("r_undef_exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("r_undef_aluwb", v_aluwb(2'b00));
    step(4);

    // BEQ taken and not taken: 3 cycles each
    set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
    expect_cycle("beq_t_fetch", v_fetch(2'b10));
    expect_cycle("beq_t_decode", v_decode(2'b10, 1'b0));
    expect_cycle("beq_t_beq", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b1000, 2'b10, 1'b0, 1'b1, 1'b0));
    step(3);
    set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
    expect_cycle("beq_nt_fetch", v_fetch(2'b10));
    expect_cycle("beq_nt_decode", v_decode(2'b10, 1'b0));
    expect_cycle("beq_nt_beq", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b1000, 2'b10, 1'b0, 1'b1, 1'b0));
    step(3);

    // JAL: 4 cycles, immSrc J
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    expect_cycle("jal_fetch", v_fetch(2'b11));
    expect_cycle("jal_decode", v_decode(2'b11, 1'b0));
    expect_cycle("jal_jal", mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0));
    expect_cycle("jal_aluwb", v_aluwb(2'b11));
    step(4);

    // LW aborted by reset during MEMREAD, then a clean LW restart
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    expect_cycle("abort_fetch", v_fetch(2'b00));
    expect_cycle("abort_decode", v_decode(2'b00, 1'b0));
    expect_cycle("abort_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    step(3);
    arst = 1'b1;
    expect_cycle("abort_in_reset", v_reset(2'b00));
    expect_cycle("abort_reset_hold", v_reset(2'b00));
    step(2);
    arst = 1'b0;
    expect_cycle("restart_fetch", v_fetch(2'b00));
    expect_cycle("restart_decode", v_decode(2'b00, 1'b0));
    step(2);
    expect_cycle("restart_memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("restart_memread", mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0));
    expect_cycle("restart_memwb", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0));
    step(3);

    // Unsupported opcode 1111111
    set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    expect_cycle("ill_fetch", v_fetch(2'b00));
    expect_cycle("ill_decode", v_decode(2'b00, 1'b0));
    for (int i = 0; i < 3; i++) begin
      expect_cycle("ill_stuck", mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1));
    end
    step(5);
    arst = 1'b1;
    expect_cycle("ill_reset", v_reset(2'b00));
    step(1);
    arst = 1'b0;
    expect_cycle("ill_after_reset_fetch", v_fetch(2'b00));
    step(1);
`else
    expect_cycle("nop_fetch", v_fetch(2'b00));
    expect_cycle("nop_decode", v_decode(2'b00, 1'b1));
    step(2);
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    expect_cycle("nop_back_fetch", v_fetch(2'b00));
    step(1);
`endif

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() != 0) begin
        @(negedge clk);
        #1;
      end
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d vectors left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
